spmv_row_accum: RTL and testbench

Row-merging reducer that drains a first-word-fall-through FIFO of sparse partial products and emits one sum per row. It sits directly downstream of `fifo_fwft` in the SpMV datapath. It consumes `{eos, row, val}` words as they appear on the FIFO head and sums runs of consecutive words that share a row index. Each completed `(row, sum)` pair goes out on a valid/ready port to the result writer.

---
 rtl/spmv_row_accum.sv | 151 +++++++++++++++
 tb/tb_spmv_row_accum.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_row_accum.sv
// rtl/spmv_row_accum.sv - merges consecutive same-row partial products from an FWFT FIFO into per-row sums
module spmv_row_accum #(
   parameter int ROW_WIDTH = 16,
   parameter int VAL_WIDTH = 32,
   parameter int ACC_WIDTH = 40,
   parameter int CNT_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ROW_WIDTH+VAL_WIDTH:0]   fifo_dout,
   input  logic                           fifo_empty,
   output logic                           fifo_rd_en,
   output logic [ROW_WIDTH-1:0]           out_row,
   output logic [ACC_WIDTH-1:0]           out_sum,
   output logic                           out_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CNT_WIDTH-1:0]           row_count,
   output logic                           busy
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_OPEN  = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [ROW_WIDTH-1:0]   h_row_q, h_row_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic                   out_valid_q, out_valid_d;
   logic [ROW_WIDTH-1:0]   out_row_q, out_row_d;
   logic [ACC_WIDTH-1:0]   out_sum_q, out_sum_d;
   logic                   out_last_q, out_last_d;
   logic [CNT_WIDTH-1:0]   row_count_q, row_count_d;

   logic                   word_eos;
   logic [ROW_WIDTH-1:0]   word_row;
   logic [VAL_WIDTH-1:0]   word_val;
   logic [ACC_WIDTH-1:0]   val_sext;
   logic                   slot_free;
   logic                   match;
   logic                   pop;
   logic                   load_slot;
   logic                   load_last;

   assign word_eos  = fifo_dout[ROW_WIDTH+VAL_WIDTH];
   assign word_row  = fifo_dout[ROW_WIDTH+VAL_WIDTH-1:VAL_WIDTH];
   assign word_val  = fifo_dout[VAL_WIDTH-1:0];
   assign val_sext  = ACC_WIDTH'($signed(word_val));
   assign slot_free = !out_valid_q || out_ready;
   assign match     = (word_row == h_row_q);

   // The FIFO head is consumed in the same cycle it is popped (FWFT), so pop is fully combinational.
   always_comb begin
      state_d   = state_q;
      h_row_d   = h_row_q;
      acc_d     = acc_q;
      pop       = 1'b0;
      load_slot = 1'b0;
      load_last = 1'b0;
      case (state_q)
         S_EMPTY: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               h_row_d = word_row;
               acc_d   = val_sext;
               state_d = word_eos ? S_FLUSH : S_OPEN;
            end
         end
         S_OPEN: begin
            if (!fifo_empty) begin
               if (match) begin
                  pop   = 1'b1;
                  acc_d = acc_q + val_sext;
                  if (word_eos) begin
                     state_d = S_FLUSH;
                  end
               end else if (slot_free) begin
                  pop       = 1'b1;
                  load_slot = 1'b1;
                  h_row_d   = word_row;
                  acc_d     = val_sext;
                  state_d   = word_eos ? S_FLUSH : S_OPEN;
               end
            end
         end
         S_FLUSH: begin
            if (slot_free) begin
               load_slot = 1'b1;
               load_last = 1'b1;
               state_d   = S_EMPTY;
            end
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase
   end

   // A reload on the handoff edge wins over the clear, so back-to-back results keep valid high.
   always_comb begin
      out_valid_d = out_valid_q;
      out_row_d   = out_row_q;
      out_sum_d   = out_sum_q;
      out_last_d  = out_last_q;
      row_count_d = row_count_q;
      if (load_slot) begin
         out_valid_d = 1'b1;
         out_row_d   = h_row_q;
         out_sum_d   = acc_q;
         out_last_d  = load_last;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (out_valid_q && out_ready) begin
         row_count_d = row_count_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_EMPTY;
         h_row_q     <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         out_sum_q   <= '0;
         out_last_q  <= 1'b0;
         row_count_q <= '0;
      end else begin
         state_q     <= state_d;
         h_row_q     <= h_row_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
         out_sum_q   <= out_sum_d;
         out_last_q  <= out_last_d;
         row_count_q <= row_count_d;
      end
   end

   assign fifo_rd_en = pop && rst;
   assign out_valid  = out_valid_q;
   assign out_row    = out_row_q;
   assign out_sum    = out_sum_q;
   assign out_last   = out_last_q;
   assign row_count  = row_count_q;
   assign busy       = (state_q != S_EMPTY) || out_valid_q;

endmodule

// File: tb/tb_spmv_row_accum.sv
// tb/tb_spmv_row_accum.sv - self-checking bench for spmv_row_accum: vector table, corner sequences, random vs. row-grouping model
module tb_spmv_row_accum;

   typedef struct packed {
      logic [15:0] row;
      logic [39:0] sum;
      logic        last;
   } res_t;

   typedef struct {
      int                n;
      logic [3:0][48:0]  w;
      int                ne;
      res_t [2:0]        e;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [48:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [15:0] out_row;
   logic [39:0] out_sum;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] row_count;
   logic        busy;

   logic [16:0] w_dout;
   logic        w_empty;
   logic        w_rd_en;
   logic [7:0]  w_out_row;
   logic [7:0]  w_out_sum;
   logic        w_out_last;
   logic        w_out_valid;
   logic        w_out_ready;
   logic [15:0] w_row_count;
   logic        w_busy;

   spmv_row_accum dut (
      .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .out_row(out_row), .out_sum(out_sum), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready), .row_count(row_count), .busy(busy)
   );

   spmv_row_accum #(.ROW_WIDTH(8), .VAL_WIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(16)) dut_w8 (
      .clk(clk), .rst(rst), .fifo_dout(w_dout), .fifo_empty(w_empty),
      .fifo_rd_en(w_rd_en), .out_row(w_out_row), .out_sum(w_out_sum), .out_last(w_out_last),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .row_count(w_row_count), .busy(w_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [48:0] fq[$];
   res_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          tot_exp = 0;
   int          ready_mode = 0;
   bit          gap_mode = 0;
   bit          last_rd = 0;
   bit          prev_hold = 0;
   logic [56:0] prev_out = '0;
   vec_t        tbl[5];

   function automatic logic [48:0] wd(input bit eos, input int row, input int val);
      return {eos, 16'(row), 32'(val)};
   endfunction

   function automatic res_t rs(input int row, input longint sum, input bit last);
      res_t r;
      r.row  = 16'(row);
      r.sum  = 40'(sum);
      r.last = last;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic expect_res(input res_t r);
      exp_q.push_back(r);
      tot_exp++;
   endtask

   // One clock: drive at negedge, check mid-low-phase, advance FIFO model on the edge.
   task automatic step();
      res_t e;
      bit   gap;
      @(negedge clk);
      gap        = gap_mode && ($urandom_range(0, 3) == 0);
      fifo_empty = (fq.size() == 0) || gap;
      fifo_dout  = fifo_empty ? {17'($urandom), 32'($urandom)} : fq[0];
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (fifo_empty) chk("rd_en_while_empty", 64'(fifo_rd_en), 64'd0);
      if (!rst) chk("rd_en_in_reset", 64'(fifo_rd_en), 64'd0);
      if (prev_hold && rst) begin
         chk("slot_stable_valid", 64'(out_valid), 64'd1);
         chk("slot_stable_data", 64'({out_row, out_sum, out_last}), 64'(prev_out));
      end
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual row=%0d sum=%0h last=%0d expected=none",
                     out_row, out_sum, out_last);
         end else begin
            e = exp_q.pop_front();
            chk("result_row", 64'(out_row), 64'(e.row));
            chk("result_sum", 64'(out_sum), 64'(e.sum));
            chk("result_last", 64'(out_last), 64'(e.last));
         end
      end
      prev_hold = rst && out_valid && !out_ready;
      prev_out  = {out_row, out_sum, out_last};
      last_rd   = fifo_rd_en;
      @(posedge clk);
      if (last_rd && fq.size() > 0) void'(fq.pop_front());
      #1;
   endtask

   task automatic drain(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (fq.size() == 0 && !busy && exp_q.size() == 0) break;
         step();
      end
      chk({name, "_drained"}, 64'(fq.size() == 0 && !busy && exp_q.size() == 0), 64'd1);
      chk({name, "_row_count"}, 64'(row_count), 64'(16'(tot_exp)));
   endtask

   initial begin
      logic [31:0] v32;
      logic [15:0] cur_row;
      logic [39:0] cur_sum;
      bit          open;
      bit          eos;
      int          row;

      rst = 1'b0;
      fifo_empty = 1'b1;
      fifo_dout = '0;
      out_ready = 1'b1;
      w_empty = 1'b1;
      w_dout = '0;
      w_out_ready = 1'b1;

      tbl[0].n = 3; tbl[0].ne = 1;
      tbl[0].w[0] = wd(0, 5, 3); tbl[0].w[1] = wd(0, 5, 4); tbl[0].w[2] = wd(1, 5, -2);
      tbl[0].e[0] = rs(5, 5, 1);
      tbl[1].n = 3; tbl[1].ne = 2;
      tbl[1].w[0] = wd(0, 1, 10); tbl[1].w[1] = wd(0, 2, 20); tbl[1].w[2] = wd(1, 2, 1);
      tbl[1].e[0] = rs(1, 10, 0); tbl[1].e[1] = rs(2, 21, 1);
      tbl[2].n = 1; tbl[2].ne = 1;
      tbl[2].w[0] = wd(1, 3, -1);
      tbl[2].e[0] = rs(3, 40'hFF_FFFF_FFFF, 1);
      tbl[3].n = 2; tbl[3].ne = 2;
      tbl[3].w[0] = wd(1, 7, 5); tbl[3].w[1] = wd(1, 7, 6);
      tbl[3].e[0] = rs(7, 5, 1); tbl[3].e[1] = rs(7, 6, 1);
      tbl[4].n = 4; tbl[4].ne = 3;
      tbl[4].w[0] = wd(0, 4, 32'h7FFF_FFFF); tbl[4].w[1] = wd(0, 4, 1);
      tbl[4].w[2] = wd(0, 9, -5); tbl[4].w[3] = wd(1, 4, 2);
      tbl[4].e[0] = rs(4, 40'h00_8000_0000, 0); tbl[4].e[1] = rs(9, -5, 0); tbl[4].e[2] = rs(4, 2, 1);

      step();
      step();
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_row", 64'(out_row), 64'd0);
      chk("reset_out_sum", 64'(out_sum), 64'd0);
      chk("reset_out_last", 64'(out_last), 64'd0);
      chk("reset_row_count", 64'(row_count), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      rst = 1'b1;

      // 8-bit accumulator wraps 127 + 1 to 0x80
      w_empty = 1'b0; w_dout = {1'b0, 8'd0, 8'd127};
      step();
      w_dout = {1'b1, 8'd0, 8'd1};
      step();
      w_empty = 1'b1;
      step();
      chk("w8_valid", 64'(w_out_valid), 64'd1);
      chk("w8_sum_wrap", 64'(w_out_sum), 64'h80);
      chk("w8_last", 64'(w_out_last), 64'd1);

      for (int t = 0; t < 5; t++) begin
         for (int j = 0; j < tbl[t].n; j++) fq.push_back(tbl[t].w[j]);
         for (int k = 0; k < tbl[t].ne; k++) expect_res(tbl[t].e[k]);
         drain($sformatf("vec%0d", t), 60);
      end

      // Row change: three back-to-back pops, eos result one cycle after its pop.
      fq.push_back(wd(0, 1, 10)); fq.push_back(wd(0, 2, 20)); fq.push_back(wd(1, 2, 1));
      expect_res(rs(1, 10, 0)); expect_res(rs(2, 21, 1));
      step(); chk("rc_pop1", 64'(last_rd), 64'd1); chk("rc_valid1", 64'(out_valid), 64'd0);
      step(); chk("rc_pop2", 64'(last_rd), 64'd1); chk("rc_valid2", 64'(out_valid), 64'd1);
      chk("rc_row2", 64'(out_row), 64'd1);
      step(); chk("rc_pop3", 64'(last_rd), 64'd1); chk("rc_valid3", 64'(out_valid), 64'd0);
      step(); chk("rc_pop4", 64'(last_rd), 64'd0); chk("rc_valid4", 64'(out_valid), 64'd1);
      chk("rc_sum4", 64'(out_sum), 64'd21); chk("rc_last4", 64'(out_last), 64'd1);
      drain("rowchange", 20);

      // Backpressure blocks a non-matching pop; release pops and reloads on the same edge.
      ready_mode = 1;
      fq.push_back(wd(0, 8, 1)); fq.push_back(wd(0, 9, 2)); fq.push_back(wd(1, 10, 4));
      expect_res(rs(8, 1, 0)); expect_res(rs(9, 2, 0)); expect_res(rs(10, 4, 1));
      step(); chk("bp_pop1", 64'(last_rd), 64'd1);
      step(); chk("bp_pop2", 64'(last_rd), 64'd1); chk("bp_slot_row", 64'(out_row), 64'd8);
      repeat (4) begin
         step(); chk("bp_blocked", 64'(last_rd), 64'd0);
      end
      ready_mode = 0;
      step(); chk("bp_release_pop", 64'(last_rd), 64'd1);
      chk("bp_reload_valid", 64'(out_valid), 64'd1);
      chk("bp_reload_row", 64'(out_row), 64'd9); chk("bp_reload_sum", 64'(out_sum), 64'd2);
      drain("backpressure", 20);

      // FIFO empty mid-row: no pop, no output, sum carries on.
      fq.push_back(wd(0, 6, 100));
      step(); chk("hold_first_pop", 64'(last_rd), 64'd1);
      repeat (10) begin
         step();
         chk("hold_no_pop", 64'(last_rd), 64'd0);
         chk("hold_no_out", 64'(out_valid), 64'd0);
      end
      fq.push_back(wd(0, 6, -30)); fq.push_back(wd(1, 6, 5));
      expect_res(rs(6, 75, 1));
      drain("emptyhold", 20);

      // Reset mid-row with a pending result discards everything.
      ready_mode = 1;
      fq.push_back(wd(0, 2, 7)); fq.push_back(wd(0, 3, 7)); fq.push_back(wd(0, 3, 1));
      step();
      step(); chk("mr_pending", 64'(out_valid), 64'd1);
      rst = 1'b0;
      step();
      chk("mr_out_valid", 64'(out_valid), 64'd0);
      chk("mr_out_row", 64'(out_row), 64'd0);
      chk("mr_out_sum", 64'(out_sum), 64'd0);
      chk("mr_out_last", 64'(out_last), 64'd0);
      chk("mr_row_count", 64'(row_count), 64'd0);
      chk("mr_busy", 64'(busy), 64'd0);
      rst = 1'b1;
      fq.delete();
      exp_q.delete();
      tot_exp = 0;
      ready_mode = 0;
      fq.push_back(wd(1, 4, 9));
      expect_res(rs(4, 9, 1));
      drain("midreset", 20);

      // Random stream with FIFO gaps and random backpressure against a run-grouping model.
      ready_mode = 2;
      gap_mode = 1;
      open = 0;
      cur_row = '0;
      cur_sum = '0;
      for (int i = 0; i < 400; i++) begin
         row = $urandom_range(0, 3);
         v32 = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 20) - 10);
         eos = ($urandom_range(0, 7) == 0) || (i == 399);
         fq.push_back({eos, 16'(row), v32});
         if (open && cur_row != 16'(row)) begin
            expect_res(rs(int'(cur_row), longint'(cur_sum), 0));
            open = 0;
         end
         if (!open) begin
            cur_row = 16'(row);
            cur_sum = 40'(longint'($signed(v32)));
            open = 1;
         end else begin
            cur_sum = cur_sum + 40'(longint'($signed(v32)));
         end
         if (eos) begin
            expect_res(rs(int'(cur_row), longint'(cur_sum), 1));
            open = 0;
         end
      end
      drain("random", 5000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
